// File: rtl/alu_ctrl_stage.sv
// alu_ctrl_stage
//   Registered ALU-control stage sitting on the ID/EX boundary. Decodes the
//   main-decoder class (ALUOp) plus funct3/funct7 into the ALU Operation code,
//   holds it with stall/flush/valid tracking, and flags and counts unsupported
//   encodings with a saturating counter.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   in_valid     ID stage presents a valid instruction
//   ALUOp        00 mem/addr, 01 branch, 10 R-type, 11 I-type ALU
//   Funct3       instruction funct3
//   Funct7       instruction funct7 (I-type: imm[11:5])
//   stall        hold register contents
//   flush        replace register contents with a bubble
//   out_valid    registered valid
//   Operation    registered ALU Operation code (all ones = bubble/illegal)
//   illegal      registered: the held op was unsupported
//   illegal_cnt  saturating count of accepted illegal ops
module alu_ctrl_stage #(
   parameter int unsigned OPCODE_LENGTH = 4,
   parameter int unsigned CNT_WIDTH     = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [1:0]               ALUOp,
   input  logic [2:0]               Funct3,
   input  logic [6:0]               Funct7,
   input  logic                     stall,
   input  logic                     flush,
   output logic                     out_valid,
   output logic [OPCODE_LENGTH-1:0] Operation,
   output logic                     illegal,
   output logic [CNT_WIDTH-1:0]     illegal_cnt
);

   typedef enum logic [3:0] {
      OP_AND    = 4'b0000,
      OP_OR     = 4'b0001,
      OP_ADD    = 4'b0010,
      OP_SUB    = 4'b0011,
      OP_XOR    = 4'b0100,
      OP_SLL    = 4'b0101,
      OP_SRL    = 4'b0110,
      OP_SLT    = 4'b0111,
      OP_EQ     = 4'b1000,
      OP_SRA    = 4'b1001,
      OP_BUBBLE = 4'b1111
   } alu_op_e;

   alu_op_e dec_op;
   logic    dec_ill;
   logic    f7_zero;
   logic    f7_alt;

   assign f7_zero = (Funct7 == 7'b0000000);
   assign f7_alt  = (Funct7 == 7'b0100000);

   // Next-state decode only; never reaches the outputs without the register.
   always_comb begin
      dec_op  = OP_BUBBLE;
      dec_ill = 1'b0;
      case (ALUOp)
         2'b00: dec_op = OP_ADD;
         2'b01: begin
            // Branch sense (BNE/BGE) is inverted downstream.
            case (Funct3)
               3'b000, 3'b001: dec_op  = OP_EQ;
               3'b100, 3'b101: dec_op  = OP_SLT;
               default:        dec_ill = 1'b1;
            endcase
         end
         2'b10: begin
            case (Funct3)
               3'b000: begin
                  if (f7_zero)     dec_op  = OP_ADD;
                  else if (f7_alt) dec_op  = OP_SUB;
                  else             dec_ill = 1'b1;
               end
               3'b101: begin
                  if (f7_zero)     dec_op  = OP_SRL;
                  else if (f7_alt) dec_op  = OP_SRA;
                  else             dec_ill = 1'b1;
               end
               // Remaining R-type ops only exist with funct7 all zero.
               3'b111: if (f7_zero) dec_op = OP_AND; else dec_ill = 1'b1;
               3'b110: if (f7_zero) dec_op = OP_OR;  else dec_ill = 1'b1;
               3'b100: if (f7_zero) dec_op = OP_XOR; else dec_ill = 1'b1;
               3'b001: if (f7_zero) dec_op = OP_SLL; else dec_ill = 1'b1;
               3'b010: if (f7_zero) dec_op = OP_SLT; else dec_ill = 1'b1;
               default: dec_ill = 1'b1;
            endcase
         end
         default: begin
            // I-type: Funct7 is immediate bits, only shifts interpret it.
            case (Funct3)
               3'b000: dec_op = OP_ADD;
               3'b111: dec_op = OP_AND;
               3'b110: dec_op = OP_OR;
               3'b100: dec_op = OP_XOR;
               3'b010: dec_op = OP_SLT;
               3'b001: if (f7_zero) dec_op = OP_SLL; else dec_ill = 1'b1;
               3'b101: begin
                  if (f7_zero)     dec_op  = OP_SRL;
                  else if (f7_alt) dec_op  = OP_SRA;
                  else             dec_ill = 1'b1;
               end
               default: dec_ill = 1'b1;
            endcase
         end
      endcase
      if (dec_ill)
         dec_op = OP_BUBBLE;
   end

   // flush > stall > load
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid   <= 1'b0;
         Operation   <= '1;
         illegal     <= 1'b0;
         illegal_cnt <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
         Operation <= '1;
         illegal   <= 1'b0;
      end else if (!stall) begin
         out_valid <= in_valid;
         if (in_valid) begin
            Operation <= dec_ill ? '1 : OPCODE_LENGTH'(dec_op);
            illegal   <= dec_ill;
            if (dec_ill && (illegal_cnt != '1))
               illegal_cnt <= illegal_cnt + 1'b1;
         end else begin
            Operation <= '1;
            illegal   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// tb_alu_ctrl_stage
//   Directed-vector bench for alu_ctrl_stage. Stimulus pushes the expected
//   registered response into a queue; a monitor pops one entry per clock and
//   compares all outputs.
module tb_alu_ctrl_stage;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic [1:0] ALUOp;
   logic [2:0] Funct3;
   logic [6:0] Funct7;
   logic       stall;
   logic       flush;
   logic       out_valid;
   logic [3:0] Operation;
   logic       illegal;
   logic [7:0] illegal_cnt;

   typedef struct {
      logic       v;
      logic [3:0] op;
      logic       ill;
      logic [7:0] cnt;
   } exp_t;

   exp_t       sb[$];
   int         n_vec  = 0;
   int         n_miss = 0;
   logic [7:0] cnt_exp = 8'd0;

   alu_ctrl_stage #(
      .OPCODE_LENGTH(4),
      .CNT_WIDTH    (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .ALUOp      (ALUOp),
      .Funct3     (Funct3),
      .Funct7     (Funct7),
      .stall      (stall),
      .flush      (flush),
      .out_valid  (out_valid),
      .Operation  (Operation),
      .illegal    (illegal),
      .illegal_cnt(illegal_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: the stage presents a registered response every cycle.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("out_valid",   {31'd0, out_valid}, {31'd0, e.v});
         chk("Operation",   {28'd0, Operation}, {28'd0, e.op});
         chk("illegal",     {31'd0, illegal},   {31'd0, e.ill});
         chk("illegal_cnt", {24'd0, illegal_cnt}, {24'd0, e.cnt});
      end
   end

   // inc: hand-determined whether this cycle should bump the illegal counter.
   task automatic step(input logic v, input logic [1:0] aop, input logic [2:0] f3,
                       input logic [6:0] f7, input logic st, input logic fl,
                       input logic ev, input logic [3:0] eop, input logic eill,
                       input logic inc);
      exp_t e;
      @(negedge clk);
      in_valid = v; ALUOp = aop; Funct3 = f3; Funct7 = f7; stall = st; flush = fl;
      if (inc && cnt_exp != 8'hFF)
         cnt_exp = cnt_exp + 8'd1;
      e.v = ev; e.op = eop; e.ill = eill; e.cnt = cnt_exp;
      sb.push_back(e);
      @(posedge clk);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_op"},    {28'd0, Operation}, 32'hF);
      chk({tag, "_ill"},   {31'd0, illegal},   32'd0);
      chk({tag, "_cnt"},   {24'd0, illegal_cnt}, 32'd0);
   endtask

   localparam logic [6:0] F0 = 7'b0000000;
   localparam logic [6:0] FA = 7'b0100000;
   localparam logic [6:0] F1 = 7'b0000001;

   initial begin
      reset = 1'b1; in_valid = 1'b0; ALUOp = 2'b00; Funct3 = 3'b000;
      Funct7 = F0; stall = 1'b0; flush = 1'b0;
      #1;
      chk_reset_state("rst0");
      @(negedge clk);
      reset = 1'b0;

      // R-type
      step(1, 2'b10, 3'b000, FA, 0, 0, 1, 4'b0011, 0, 0);
      step(1, 2'b10, 3'b000, F0, 0, 0, 1, 4'b0010, 0, 0);
      step(1, 2'b10, 3'b101, FA, 0, 0, 1, 4'b1001, 0, 0);
      step(1, 2'b10, 3'b101, F0, 0, 0, 1, 4'b0110, 0, 0);
      step(1, 2'b10, 3'b011, F0, 0, 0, 1, 4'b1111, 1, 1);
      step(1, 2'b10, 3'b111, F0, 0, 0, 1, 4'b0000, 0, 0);
      step(1, 2'b10, 3'b110, F0, 0, 0, 1, 4'b0001, 0, 0);
      step(1, 2'b10, 3'b100, F0, 0, 0, 1, 4'b0100, 0, 0);
      step(1, 2'b10, 3'b001, F0, 0, 0, 1, 4'b0101, 0, 0);
      step(1, 2'b10, 3'b010, F0, 0, 0, 1, 4'b0111, 0, 0);
      step(1, 2'b10, 3'b111, FA, 0, 0, 1, 4'b1111, 1, 1);
      step(1, 2'b10, 3'b000, F1, 0, 0, 1, 4'b1111, 1, 1);
      // I-type
      step(1, 2'b11, 3'b001, F1, 0, 0, 1, 4'b1111, 1, 1);
      step(1, 2'b11, 3'b001, F0, 0, 0, 1, 4'b0101, 0, 0);
      step(1, 2'b11, 3'b000, FA, 0, 0, 1, 4'b0010, 0, 0);
      step(1, 2'b11, 3'b101, FA, 0, 0, 1, 4'b1001, 0, 0);
      step(1, 2'b11, 3'b101, F1, 0, 0, 1, 4'b1111, 1, 1);
      step(1, 2'b11, 3'b011, F0, 0, 0, 1, 4'b1111, 1, 1);
      step(1, 2'b11, 3'b110, F1, 0, 0, 1, 4'b0001, 0, 0);
      // Branch
      step(1, 2'b01, 3'b101, F0, 0, 0, 1, 4'b0111, 0, 0);
      step(1, 2'b01, 3'b000, F0, 0, 0, 1, 4'b1000, 0, 0);
      step(1, 2'b01, 3'b001, F1, 0, 0, 1, 4'b1000, 0, 0);
      step(1, 2'b01, 3'b100, F0, 0, 0, 1, 4'b0111, 0, 0);
      step(1, 2'b01, 3'b010, F0, 0, 0, 1, 4'b1111, 1, 1);
      // Mem/addr: funct fields are don't-care
      for (int i = 0; i < 4; i++)
         step(1, 2'b00, 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)),
              0, 0, 1, 4'b0010, 0, 0);
      // Invalid input loads a bubble, no count even if encoding is illegal
      step(0, 2'b10, 3'b011, F0, 0, 0, 0, 4'b1111, 0, 0);

      // Stall: load ADD, stall 3 cycles with XOR on inputs, then release
      step(1, 2'b00, 3'b000, F0, 0, 0, 1, 4'b0010, 0, 0);
      for (int i = 0; i < 3; i++)
         step(1, 2'b10, 3'b100, F0, 1, 0, 1, 4'b0010, 0, 0);
      step(1, 2'b10, 3'b100, F0, 0, 0, 1, 4'b0100, 0, 0);
      // Stall blocks the count on an illegal input
      step(1, 2'b10, 3'b011, F0, 0, 0, 1, 4'b1111, 1, 1);
      step(1, 2'b10, 3'b011, F0, 1, 0, 1, 4'b1111, 1, 0);
      // Stall + flush with an illegal input: flush wins, no count
      step(1, 2'b10, 3'b011, F0, 1, 1, 0, 4'b1111, 0, 0);
      // Flush with a legal input
      step(1, 2'b10, 3'b000, F0, 0, 0, 1, 4'b0010, 0, 0);
      step(1, 2'b10, 3'b000, FA, 0, 1, 0, 4'b1111, 0, 0);
      step(1, 2'b10, 3'b000, FA, 1, 0, 0, 4'b1111, 0, 0);
      step(1, 2'b10, 3'b000, FA, 0, 0, 1, 4'b0011, 0, 0);

      // Mid-stream asynchronous reset while out_valid=1
      #2;
      reset = 1'b1;
      #1;
      chk_reset_state("rst_mid");
      cnt_exp = 8'd0;
      @(negedge clk);
      reset = 1'b0;
      step(1, 2'b10, 3'b110, F0, 0, 0, 1, 4'b0001, 0, 0);

      // Saturation: 260 consecutive illegal ops, counter stops at 255
      for (int i = 0; i < 260; i++)
         step(1, 2'b10, 3'b011, F0, 0, 0, 1, 4'b1111, 1, 1);
      step(1, 2'b01, 3'b111, F0, 0, 0, 1, 4'b1111, 1, 1);
      step(1, 2'b10, 3'b100, F0, 0, 0, 1, 4'b0100, 0, 0);

      @(negedge clk);
      chk("scoreboard_drained", sb.size(), 32'd0);
      chk("sat_cnt", {24'd0, illegal_cnt}, 32'd255);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
